// File: rtl/gate_pkg.sv
// Shared encodings for the gate tester: expected-function selector and FSM states.
package gate_pkg;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_NAND = 3'd2,
        GATE_NOR  = 3'd3,
        GATE_XOR  = 3'd4,
        GATE_XNOR = 3'd5,
        GATE_NOT  = 3'd6,
        GATE_BUF  = 3'd7
    } gate_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } state_e;

endpackage

// File: rtl/gate_tester_if.sv
// Control/status and gate-under-test signals of the gate tester, bundled as one interface.
interface gate_tester_if #(
    parameter int N_IN = 2
) ();
    logic            start;
    logic [2:0]      gate_sel;
    logic [N_IN-1:0] dut_in;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail;

    modport master (
        output start, gate_sel, dut_y,
        input  dut_in, busy, done, pass, err_count, fail_valid, first_fail
    );

    modport slave (
        input  start, gate_sel, dut_y,
        output dut_in, busy, done, pass, err_count, fail_valid, first_fail
    );
endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference: expected gate output for a selector and input vector.
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      sel,
    input  logic [N_IN-1:0] vec,
    output logic            expected
);

    always_comb begin
        expected = 1'b0;
        case (sel)
            GATE_AND:  expected = &vec;
            GATE_OR:   expected = |vec;
            GATE_NAND: expected = ~(&vec);
            GATE_NOR:  expected = ~(|vec);
            GATE_XOR:  expected = ^vec;
            GATE_XNOR: expected = ~(^vec);
            GATE_NOT:  expected = ~vec[0];
            GATE_BUF:  expected = vec[0];
            default:   expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tester.sv
// Walks every input vector through a gate under test, holding SETTLE cycles then sampling,
// and records error count, first failing vector and an overall pass flag.
module gate_tester
    import gate_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input logic         clk,
    input logic         rst,
    gate_tester_if.slave bus
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN:0]    ERR_ONE  = (N_IN+1)'(1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fail_valid_q, fail_valid_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;
    logic            pass_q, pass_d;
    logic            expected;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .sel      (sel_q),
        .vec      (vec_q),
        .expected (expected)
    );

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sel_d        = bus.gate_sel;
                    vec_d        = '0;
                    cnt_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_SAMPLE: begin
                if (bus.dut_y != expected) begin
                    err_d = err_q + ERR_ONE;
                    if (!fail_valid_q) begin
                        first_fail_d = vec_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (vec_q == '1) begin
                    state_d = ST_FIN;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_FIN: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            sel_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        bus.busy       = (state_q == ST_HOLD) || (state_q == ST_SAMPLE);
        bus.dut_in     = bus.busy ? vec_q : '0;
        bus.done       = (state_q == ST_FIN);
        bus.pass       = pass_q;
        bus.err_count  = err_q;
        bus.fail_valid = fail_valid_q;
        bus.first_fail = first_fail_q;
    end

endmodule
